// File: rtl/cache_data_array.sv
// cache_data_array
//
// Set-associative cache data store. A read returns one beat (a slice of a
// cache line) from every way of the addressed set, one cycle after the
// request. Writes come from one of two sources, one per cycle: a single-beat
// byte-enabled write port, or an internal line-fill engine that streams the
// beats of a full line into a latched {way, set}. Reads that hit the location
// being written in the same cycle see the new bytes (write-first).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   rd_en, rd_set, rd_beat           read request / set index / beat in line
//   rd_data, rd_valid                all ways' beats (way w at w*BEAT_BITS),
//                                    valid pulse one cycle after rd_en
//   wr_en, wr_ready                  single-beat write handshake
//   wr_way, wr_set, wr_beat          write target
//   wr_data, wr_be                   write data and byte enables
//   fill_start, fill_way, fill_set   start a line fill into {way, set}
//   fill_valid, fill_data, fill_ready fill beat handshake, beat 0 first
//   fill_busy                        fill in progress
//   fill_done                        pulse in the cycle after the last beat

module cache_data_array #(
  parameter int WAYS      = 4,
  parameter int SETS      = 256,
  parameter int LINE_BITS = 512,
  parameter int BEAT_BITS = 128,
  localparam int BEATS    = LINE_BITS / BEAT_BITS,
  localparam int SET_W    = $clog2(SETS),
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WAY_W    = $clog2(WAYS),
  localparam int BE_W     = BEAT_BITS / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [SET_W-1:0]          rd_set,
  input  logic [BEAT_W-1:0]         rd_beat,
  output logic [WAYS*BEAT_BITS-1:0] rd_data,
  output logic                      rd_valid,
  input  logic                      wr_en,
  output logic                      wr_ready,
  input  logic [WAY_W-1:0]          wr_way,
  input  logic [SET_W-1:0]          wr_set,
  input  logic [BEAT_W-1:0]         wr_beat,
  input  logic [BEAT_BITS-1:0]      wr_data,
  input  logic [BE_W-1:0]           wr_be,
  input  logic                      fill_start,
  input  logic [WAY_W-1:0]          fill_way,
  input  logic [SET_W-1:0]          fill_set,
  input  logic                      fill_valid,
  input  logic [BEAT_BITS-1:0]      fill_data,
  output logic                      fill_ready,
  output logic                      fill_busy,
  output logic                      fill_done
);

  // Rows per way are indexed by {set, beat}; sizing by the full BEAT_W range
  // keeps the index width exactly matched to the row count.
  localparam int ADDR_W = SET_W + BEAT_W;
  localparam int ROWS   = 1 << ADDR_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WAY_W-1:0]  fill_way_q;
  logic [SET_W-1:0]  fill_set_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              fill_done_q;

  logic              fill_accept;
  logic              wr_accept;
  logic              fill_last;

  logic              w_en;
  logic [WAY_W-1:0]  w_way;
  logic [ADDR_W-1:0] w_addr;
  logic [BEAT_BITS-1:0] w_data;
  logic [BE_W-1:0]   w_be;

  logic [ADDR_W-1:0] rd_addr;
  logic [WAYS*BEAT_BITS-1:0] rd_next;
  logic [WAYS*BEAT_BITS-1:0] rd_data_p1;
  logic              vld_p1;

  logic [BEAT_BITS-1:0] mem [WAYS][ROWS];

  // Replace the enabled bytes of old_word with the matching bytes of new_word.
  function automatic logic [BEAT_BITS-1:0] byte_merge(
    input logic [BEAT_BITS-1:0] old_word,
    input logic [BEAT_BITS-1:0] new_word,
    input logic [BE_W-1:0]      be
  );
    logic [BEAT_BITS-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fill_start) state_nxt = FILL;
      FILL: if (fill_accept && fill_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_ready   = 1'b0;
    fill_ready = 1'b0;
    fill_busy  = 1'b0;
    case (state)
      IDLE: wr_ready = 1'b1;
      FILL: begin
        fill_ready = 1'b1;
        fill_busy  = 1'b1;
      end
      default: wr_ready = 1'b0;
    endcase
  end

  assign fill_accept = fill_valid & fill_ready;
  assign wr_accept   = wr_en & wr_ready;
  assign fill_last   = (beat_cnt == LAST_BEAT);
  assign fill_done   = fill_done_q;

  // Fill target latch and beat counter. fill_start is only looked at in IDLE,
  // so a second start during a fill cannot disturb the latched target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_way_q  <= '0;
      fill_set_q  <= '0;
      beat_cnt    <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= fill_accept & fill_last;
      if (state == IDLE && fill_start) begin
        fill_way_q <= fill_way;
        fill_set_q <= fill_set;
        beat_cnt   <= '0;
      end else if (fill_accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Single write port into the array: the FSM state decides whether the fill
  // engine or the external write owns it, so the two never collide.
  always_comb begin
    w_en   = wr_accept;
    w_way  = wr_way;
    w_addr = {wr_set, wr_beat};
    w_data = wr_data;
    w_be   = wr_be;
    if (state == FILL) begin
      w_en   = fill_accept;
      w_way  = fill_way_q;
      w_addr = {fill_set_q, beat_cnt};
      w_data = fill_data;
      w_be   = '1;
    end
  end

  // Array contents carry no reset.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_be[b]) mem[w_way][w_addr][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read path with write-first forwarding into the written way only.
  assign rd_addr = {rd_set, rd_beat};

  always_comb begin
    rd_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_en && (w_way == WAY_W'(w)) && (w_addr == rd_addr))
        rd_next[w*BEAT_BITS +: BEAT_BITS] = byte_merge(mem[w][rd_addr], w_data, w_be);
      else
        rd_next[w*BEAT_BITS +: BEAT_BITS] = mem[w][rd_addr];
    end
  end

  // Stage p1: registered read data; holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_data_p1 <= rd_next;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array
//
// Directed bench for cache_data_array at default parameters (4 ways, 256 sets,
// 4 beats of 128 bits). A line-level reference model holds the expected array
// contents and the fill progress; a compare process checks every output on
// every falling edge, and the directed sequence adds hand-computed literals.

module tb_cache_data_array;

  localparam int WAYS = 4;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_en;
  logic [7:0]   rd_set;
  logic [1:0]   rd_beat;
  logic [511:0] rd_data;
  logic         rd_valid;
  logic         wr_en;
  logic         wr_ready;
  logic [1:0]   wr_way;
  logic [7:0]   wr_set;
  logic [1:0]   wr_beat;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         fill_start;
  logic [1:0]   fill_way;
  logic [7:0]   fill_set;
  logic         fill_valid;
  logic [127:0] fill_data;
  logic         fill_ready;
  logic         fill_busy;
  logic         fill_done;

  cache_data_array dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_set(rd_set), .rd_beat(rd_beat),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_way(wr_way), .wr_set(wr_set),
    .wr_beat(wr_beat), .wr_data(wr_data), .wr_be(wr_be),
    .fill_start(fill_start), .fill_way(fill_way), .fill_set(fill_set),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int w, input int s, input int b);
    return {4{8'(w), 8'(s), 8'(b), 8'h5A}};
  endfunction

  // ---------------- reference model ----------------
  logic [127:0] m_mem [WAYS][256][BEATS];
  bit           m_filling = 1'b0;
  int           m_way = 0, m_set = 0, m_cnt = 0;
  bit           exp_valid = 1'b0;
  logic [511:0] exp_data = '0;
  bit           exp_done = 1'b0;
  bit           m_we;
  int           m_ww, m_ws, m_wb;
  logic [127:0] m_wd;
  logic [15:0]  m_wbe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_filling = 1'b0;
      m_cnt     = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_done  = 1'b0;
    end else begin
      m_we = 1'b0;
      if (!m_filling && wr_en) begin
        m_we = 1'b1; m_ww = wr_way; m_ws = wr_set; m_wb = wr_beat;
        m_wd = wr_data; m_wbe = wr_be;
      end else if (m_filling && fill_valid) begin
        m_we = 1'b1; m_ww = m_way; m_ws = m_set; m_wb = m_cnt;
        m_wd = fill_data; m_wbe = '1;
      end
      // Write-first: the write lands before the same-cycle read looks.
      if (m_we)
        for (int i = 0; i < 16; i++)
          if (m_wbe[i]) m_mem[m_ww][m_ws][m_wb][8*i +: 8] = m_wd[8*i +: 8];
      exp_valid = rd_en;
      if (rd_en)
        for (int w = 0; w < WAYS; w++) exp_data[128*w +: 128] = m_mem[w][rd_set][rd_beat];
      exp_done = m_filling && fill_valid && (m_cnt == BEATS - 1);
      if (!m_filling) begin
        if (fill_start) begin
          m_filling = 1'b1; m_way = fill_way; m_set = fill_set; m_cnt = 0;
        end
      end else if (fill_valid) begin
        m_cnt++;
        if (m_cnt == BEATS) m_filling = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("rd_valid", rd_valid, exp_valid);
    if (exp_valid) check("rd_data", rd_data, exp_data);
    check("wr_ready", wr_ready, !m_filling);
    check("fill_busy", fill_busy, m_filling);
    check("fill_ready", fill_ready, m_filling);
    check("fill_done", fill_done, exp_done);
    if (fill_done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input int w, input int s, input int b,
                          input logic [127:0] d, input logic [15:0] be);
    wr_en = 1'b1; wr_way = 2'(w); wr_set = 8'(s); wr_beat = 2'(b);
    wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int s, input int b);
    rd_en = 1'b1; rd_set = 8'(s); rd_beat = 2'(b);
    tick();
    rd_en = 1'b0;
  endtask

  int sets_used [3] = '{5, 7, 9};

  initial begin
    rst_n = 1'b0;
    rd_en = 0; rd_set = 0; rd_beat = 0;
    wr_en = 0; wr_way = 0; wr_set = 0; wr_beat = 0; wr_data = 0; wr_be = 0;
    fill_start = 0; fill_way = 0; fill_set = 0; fill_valid = 0; fill_data = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, '0);
    check("reset_fill_busy", fill_busy, 0);
    check("reset_fill_ready", fill_ready, 0);
    check("reset_fill_done", fill_done, 0);
    check("reset_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    tick();

    // preload every location the sequence reads
    foreach (sets_used[i])
      for (int w = 0; w < WAYS; w++)
        for (int b = 0; b < BEATS; b++)
          do_write(w, sets_used[i], b, pat(w, sets_used[i], b), '1);

    // single write then read
    do_write(2, 5, 1, {16{8'hA5}}, '1);
    do_read(5, 1);
    check("single_valid", rd_valid, 1);
    check("single_way2", rd_data[256 +: 128], {16{8'hA5}});
    check("single_way0", rd_data[0 +: 128], 128'h0005015A_0005015A_0005015A_0005015A);
    tick();
    check("rd_valid_pulse", rd_valid, 0);
    check("rd_data_hold", rd_data[256 +: 128], {16{8'hA5}});

    // partial byte write, then an all-disabled write
    do_write(0, 5, 0, '1, '1);
    do_write(0, 5, 0, 128'h12, 16'h0001);
    do_read(5, 0);
    check("partial_byte", rd_data[0 +: 128], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF12);
    do_write(0, 5, 0, '0, 16'h0000);
    do_read(5, 0);
    check("be_zero_noop", rd_data[0 +: 128], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF12);

    // same-cycle read/write collision
    for (int w = 0; w < WAYS; w++) do_write(w, 7, 3, {16{8'hAA}}, '1);
    rd_en = 1'b1; rd_set = 8'd7; rd_beat = 2'd3;
    wr_en = 1'b1; wr_way = 2'd1; wr_set = 8'd7; wr_beat = 2'd3;
    wr_data = 128'hDEADBEEF_DEADBEEF_12345678_12345678; wr_be = 16'h00FF;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    check("collide_way1", rd_data[128 +: 128], 128'hAAAAAAAA_AAAAAAAA_12345678_12345678);
    check("collide_way0", rd_data[0 +: 128], {16{8'hAA}});
    check("collide_way3", rd_data[384 +: 128], {16{8'hAA}});

    // line fill with a gap
    fill_start = 1'b1; fill_way = 2'd3; fill_set = 8'd9;
    tick();
    fill_start = 1'b0;
    check("fill_wr_ready", wr_ready, 0);
    check("fill_busy_on", fill_busy, 1);
    fill_valid = 1'b1; fill_data = 128'h1; tick();
    fill_data = 128'h2; tick();
    fill_valid = 1'b0; tick();
    check("fill_gap_busy", fill_busy, 1);
    fill_valid = 1'b1; fill_data = 128'h3; tick();
    fill_data = 128'h4; tick();
    fill_valid = 1'b0;
    check("fill_done_pulse", fill_done, 1);
    check("fill_idle_wr_ready", wr_ready, 1);
    tick();
    check("fill_done_clear", fill_done, 0);
    check("fill_done_count", done_cnt, 1);
    for (int b = 0; b < BEATS; b++) begin
      do_read(9, b);
      check("fill_beat", rd_data[384 +: 128], 128'(b + 1));
    end

    // back-pressure and ignored second start
    fill_start = 1'b1; fill_way = 2'd0; fill_set = 8'd9;
    tick();
    wr_en = 1'b1; wr_way = 2'd1; wr_set = 8'd9; wr_beat = 2'd2;
    wr_data = {4{32'hBEEF0001}}; wr_be = '1;
    fill_start = 1'b1; fill_way = 2'd1; fill_set = 8'd7;
    fill_valid = 1'b1; fill_data = 128'h10;
    rd_en = 1'b1; rd_set = 8'd9; rd_beat = 2'd2;
    tick();
    rd_en = 1'b0; fill_start = 1'b0;
    check("bp_no_write", rd_data[128 +: 128], 128'h0109025A_0109025A_0109025A_0109025A);
    check("bp_wr_ready", wr_ready, 0);
    fill_data = 128'h11; tick();
    fill_data = 128'h12; tick();
    fill_data = 128'h13; tick();
    fill_valid = 1'b0;
    check("bp_exit_wr_ready", wr_ready, 1);
    tick();
    wr_en = 1'b0;
    check("bp_done_count", done_cnt, 2);
    do_read(9, 2);
    check("bp_late_write", rd_data[128 +: 128], {4{32'hBEEF0001}});
    check("bp_fill_way0", rd_data[0 +: 128], 128'h12);
    do_read(7, 0);
    check("bp_target_kept", rd_data[128 +: 128], 128'h0107005A_0107005A_0107005A_0107005A);

    // reset in the middle of a fill
    fill_start = 1'b1; fill_way = 2'd2; fill_set = 8'd5;
    tick();
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_data = 128'hB0; tick();
    fill_data = 128'hB1; tick();
    fill_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", fill_busy, 0);
    check("rst_mid_ready", fill_ready, 0);
    check("rst_mid_done", fill_done, 0);
    check("rst_mid_rd_data", rd_data, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_done_count", done_cnt, 2);
    do_read(5, 0);
    check("rst_beat0", rd_data[256 +: 128], 128'hB0);
    do_read(5, 1);
    check("rst_beat1", rd_data[256 +: 128], 128'hB1);
    do_read(5, 2);
    check("rst_beat2", rd_data[256 +: 128], 128'h0205025A_0205025A_0205025A_0205025A);
    do_read(5, 3);
    check("rst_beat3", rd_data[256 +: 128], 128'h0205035A_0205035A_0205035A_0205035A);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
